// File: rtl/entry_beat_serializer_pkg.sv
// Shared definitions for entry_beat_serializer.
// Contents:
//   - BYTE_LEN_IN_BITS : byte width used across the queueing blocks.
//   - state_e          : serializer FSM encoding (IDLE = 0, SEND = 1).
package entry_beat_serializer_pkg;

  localparam int unsigned BYTE_LEN_IN_BITS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/entry_beat_serializer.sv
// Pops one wide entry from an upstream queue and emits it as a run of narrower
// beats under a valid/ack handshake. The upstream pop happens at capture, so
// the queue slot frees while the beats drain.
// Ports:
//   clk_in            clock
//   reset_n_in        asynchronous active-low reset
//   request_in        upstream entry
//   request_valid_in  upstream entry valid
//   issue_ack_out     upstream pop (combinational, single cycle per entry)
//   beat_out          current beat (registered)
//   beat_valid_out    beat valid (registered)
//   beat_last_out     final beat of the entry (registered)
//   beat_ack_in       downstream accepts the current beat
//   busy_out          an entry is held (SEND state)
module entry_beat_serializer
  import entry_beat_serializer_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned BEAT_WIDTH_IN_BITS         = 16,
  parameter int unsigned NUM_BEATS                  = SINGLE_ENTRY_WIDTH_IN_BITS / BEAT_WIDTH_IN_BITS,
  parameter int unsigned BEAT_CNT_WIDTH_IN_BITS     = $clog2(NUM_BEATS),
  parameter string       MSB_FIRST                  = "No"
) (
  input  logic                                  clk_in,
  input  logic                                  reset_n_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
  input  logic                                  request_valid_in,
  output logic                                  issue_ack_out,
  output logic [BEAT_WIDTH_IN_BITS-1:0]         beat_out,
  output logic                                  beat_valid_out,
  output logic                                  beat_last_out,
  input  logic                                  beat_ack_in,
  output logic                                  busy_out
);

  if (((SINGLE_ENTRY_WIDTH_IN_BITS % BEAT_WIDTH_IN_BITS) != 0) || (NUM_BEATS < 2)) begin : g_param_check
    $error("entry_beat_serializer: entry width must be a multiple of beat width with at least 2 beats");
  end

  localparam bit MSB_SEL = (MSB_FIRST == "Yes");
  localparam logic [BEAT_CNT_WIDTH_IN_BITS-1:0] LAST_CNT = BEAT_CNT_WIDTH_IN_BITS'(NUM_BEATS - 1);

  state_e                                  state_q, state_d;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]   shreg_q, shreg_d;
  logic [BEAT_CNT_WIDTH_IN_BITS-1:0]       cnt_q, cnt_d;
  logic                                    beat_valid_q, beat_valid_d;
  logic                                    beat_last_q, beat_last_d;

  logic xfer;
  logic load;

  assign xfer = beat_valid_q & beat_ack_in;

  // Load in IDLE, or on the last-beat transfer so consecutive entries run with
  // no bubble. Gated by reset so no pop escapes while the block is held.
  assign load = reset_n_in & request_valid_in &
                ((state_q == IDLE) | ((state_q == SEND) & beat_last_q & beat_ack_in));

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    beat_valid_d = beat_valid_q;
    beat_last_d  = beat_last_q;
    if (load) begin
      state_d      = SEND;
      shreg_d      = request_in;
      cnt_d        = '0;
      beat_valid_d = 1'b1;
      beat_last_d  = 1'b0;
    end else if (xfer) begin
      // Vacated slices are zero-filled, so the register drains to zero.
      shreg_d = MSB_SEL ? (shreg_q << BEAT_WIDTH_IN_BITS) : (shreg_q >> BEAT_WIDTH_IN_BITS);
      if (beat_last_q) begin
        state_d      = IDLE;
        beat_valid_d = 1'b0;
        beat_last_d  = 1'b0;
      end else begin
        cnt_d       = cnt_q + BEAT_CNT_WIDTH_IN_BITS'(1);
        beat_last_d = ((cnt_q + BEAT_CNT_WIDTH_IN_BITS'(1)) == LAST_CNT);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      beat_valid_q <= 1'b0;
      beat_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      beat_valid_q <= beat_valid_d;
      beat_last_q  <= beat_last_d;
    end
  end

  assign issue_ack_out  = load;
  assign beat_out       = MSB_SEL ? shreg_q[SINGLE_ENTRY_WIDTH_IN_BITS-1 -: BEAT_WIDTH_IN_BITS]
                                  : shreg_q[BEAT_WIDTH_IN_BITS-1:0];
  assign beat_valid_out = beat_valid_q;
  assign beat_last_out  = beat_last_q;
  assign busy_out       = (state_q == SEND);

endmodule

// File: tb/tb_entry_beat_serializer.sv
module tb_entry_beat_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] req = '0;
  logic        rv = 1'b0;
  logic        ack = 1'b0;

  logic        iack_l, bv_l, bl_l, busy_l;
  logic [15:0] beat_l;
  logic        iack_m, bv_m, bl_m, busy_m;
  logic [15:0] beat_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  entry_beat_serializer #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(64),
    .BEAT_WIDTH_IN_BITS(16),
    .MSB_FIRST("No")
  ) dut_lsb (
    .clk_in(clk), .reset_n_in(rst_n), .request_in(req), .request_valid_in(rv),
    .issue_ack_out(iack_l), .beat_out(beat_l), .beat_valid_out(bv_l),
    .beat_last_out(bl_l), .beat_ack_in(ack), .busy_out(busy_l)
  );

  entry_beat_serializer #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(64),
    .BEAT_WIDTH_IN_BITS(16),
    .MSB_FIRST("Yes")
  ) dut_msb (
    .clk_in(clk), .reset_n_in(rst_n), .request_in(req), .request_valid_in(rv),
    .issue_ack_out(iack_m), .beat_out(beat_m), .beat_valid_out(bv_m),
    .beat_last_out(bl_m), .beat_ack_in(ack), .busy_out(busy_m)
  );

  typedef struct {
    logic        rv;
    logic [63:0] req;
    logic        ack;
    logic        e_iack;
    logic [15:0] e_lsb;
    logic [15:0] e_msb;
    logic        e_v;
    logic        e_last;
    logic        e_busy;
  } vec_t;

  localparam logic [63:0] ENT_E = 64'h4444_3333_2222_1111;
  localparam logic [63:0] ENT_F = 64'h8888_7777_6666_5555;
  localparam logic [63:0] ENT_G = 64'hDDDD_CCCC_BBBB_AAAA;
  localparam logic [63:0] ENT_H = 64'h0004_0003_0002_0001;

  vec_t vecs[20];

  function automatic vec_t mk(logic a_rv, logic [63:0] a_req, logic a_ack, logic ei,
                              logic [15:0] el, logic [15:0] em, logic ev, logic elst, logic eb);
    vec_t v;
    v.rv = a_rv; v.req = a_req; v.ack = a_ack; v.e_iack = ei;
    v.e_lsb = el; v.e_msb = em; v.e_v = ev; v.e_last = elst; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] qm[$];
    int got;
    int n_ack;

    // single entry, LSB/MSB order, then idle
    vecs[0]  = mk(1, ENT_E, 1, 1, 16'h0000, 16'h0000, 0, 0, 0);
    vecs[1]  = mk(0, '0,    1, 0, 16'h1111, 16'h4444, 1, 0, 1);
    vecs[2]  = mk(0, '0,    1, 0, 16'h2222, 16'h3333, 1, 0, 1);
    vecs[3]  = mk(0, '0,    1, 0, 16'h3333, 16'h2222, 1, 0, 1);
    vecs[4]  = mk(0, '0,    1, 0, 16'h4444, 16'h1111, 1, 1, 1);
    vecs[5]  = mk(0, '0,    1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    // backpressure on beat 1 with a new entry waiting, then back-to-back load
    vecs[6]  = mk(1, ENT_E, 1, 1, 16'h0000, 16'h0000, 0, 0, 0);
    vecs[7]  = mk(0, '0,    1, 0, 16'h1111, 16'h4444, 1, 0, 1);
    vecs[8]  = mk(1, ENT_F, 0, 0, 16'h2222, 16'h3333, 1, 0, 1);
    vecs[9]  = mk(1, ENT_F, 0, 0, 16'h2222, 16'h3333, 1, 0, 1);
    vecs[10] = mk(1, ENT_F, 0, 0, 16'h2222, 16'h3333, 1, 0, 1);
    vecs[11] = mk(1, ENT_F, 1, 0, 16'h2222, 16'h3333, 1, 0, 1);
    vecs[12] = mk(1, ENT_F, 1, 0, 16'h3333, 16'h2222, 1, 0, 1);
    vecs[13] = mk(1, ENT_F, 1, 1, 16'h4444, 16'h1111, 1, 1, 1);
    vecs[14] = mk(0, '0,    1, 0, 16'h5555, 16'h8888, 1, 0, 1);
    vecs[15] = mk(0, '0,    1, 0, 16'h6666, 16'h7777, 1, 0, 1);
    vecs[16] = mk(0, '0,    1, 0, 16'h7777, 16'h6666, 1, 0, 1);
    // last beat stalled with valid upstream: no pop until the beat transfers
    vecs[17] = mk(1, ENT_E, 0, 0, 16'h8888, 16'h5555, 1, 1, 1);
    vecs[18] = mk(0, '0,    1, 0, 16'h8888, 16'h5555, 1, 1, 1);
    vecs[19] = mk(0, '0,    1, 0, 16'h0000, 16'h0000, 0, 0, 0);

    // reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rv  = 1'($urandom);
      ack = 1'($urandom);
      req = {$urandom, $urandom};
      #1;
      chk($sformatf("reset_hold[%0d]", i),
          {28'd0, iack_l, bv_l, bl_l, busy_l, beat_l, iack_m, bv_m, bl_m, busy_m, beat_m}, '0);
    end
    @(negedge clk);
    rst_n = 1'b1; rv = 1'b0; ack = 1'b0; req = '0;

    // table-driven vectors
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rv = vecs[i].rv; req = vecs[i].req; ack = vecs[i].ack;
      #1;
      chk($sformatf("v%0d.iack_l", i), {63'd0, iack_l}, {63'd0, vecs[i].e_iack});
      chk($sformatf("v%0d.iack_m", i), {63'd0, iack_m}, {63'd0, vecs[i].e_iack});
      chk($sformatf("v%0d.beat_l", i), {48'd0, beat_l}, {48'd0, vecs[i].e_lsb});
      chk($sformatf("v%0d.beat_m", i), {48'd0, beat_m}, {48'd0, vecs[i].e_msb});
      chk($sformatf("v%0d.valid", i), {62'd0, bv_l, bv_m}, {62'd0, vecs[i].e_v, vecs[i].e_v});
      chk($sformatf("v%0d.last", i), {62'd0, bl_l, bl_m}, {62'd0, vecs[i].e_last, vecs[i].e_last});
      chk($sformatf("v%0d.busy", i), {62'd0, busy_l, busy_m}, {62'd0, vecs[i].e_busy, vecs[i].e_busy});
    end

    // upstream queue of depth 4 drained back-to-back
    for (int k = 0; k < 4; k++)
      qm.push_back({16'hA000 + 16'(4*k+3), 16'hA000 + 16'(4*k+2),
                    16'hA000 + 16'(4*k+1), 16'hA000 + 16'(4*k)});
    got = 0; n_ack = 0;
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      @(negedge clk);
      rv  = (qm.size() != 0);
      req = rv ? qm[0] : '0;
      ack = 1'b1;
      #1;
      if (bv_l && ack) begin
        chk($sformatf("queue.beat%0d", got), {48'd0, beat_l}, {48'd0, 16'hA000 + 16'(got)});
        got++;
      end
      if (iack_l) begin
        n_ack++;
        void'(qm.pop_front());
      end
    end
    chk("queue.beats_seen", 64'(got), 64'd16);
    chk("queue.ack_pulses", 64'(n_ack), 64'd4);
    chk("queue.empty", 64'(qm.size()), 64'd0);
    @(negedge clk);
    rv = 1'b0; #1;
    chk("queue.idle_after", {62'd0, bv_l, busy_l}, '0);

    // reset in the middle of an entry, then a fresh entry
    @(negedge clk);
    rv = 1'b1; req = ENT_G; ack = 1'b1;
    @(negedge clk);
    rv = 1'b0; req = '0; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #1;
    chk("midreset.beat1_before", {48'd0, beat_l}, {48'd0, 16'hBBBB});
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset.outputs_zero",
        {28'd0, iack_l, bv_l, bl_l, busy_l, beat_l, iack_m, bv_m, bl_m, busy_m, beat_m}, '0);
    @(negedge clk);
    rst_n = 1'b1; rv = 1'b1; req = ENT_H; ack = 1'b1;
    #1;
    chk("midreset.new_iack", {63'd0, iack_l}, 64'd1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      rv = 1'b0; req = '0;
      #1;
      chk($sformatf("midreset.new_beat%0d", b), {48'd0, beat_l}, {48'd0, 16'(b + 1)});
      chk($sformatf("midreset.new_msb%0d", b), {48'd0, beat_m}, {48'd0, 16'(4 - b)});
      chk($sformatf("midreset.new_last%0d", b), {62'd0, bl_l, bv_l}, {62'd0, (b == 3), 1'b1});
    end
    @(negedge clk);
    #1;
    chk("midreset.idle_after", {62'd0, bv_l, busy_l}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
